// File: rtl/line_window_buffer.sv
// line_window_buffer
// Streams a frame from a row memory as a sliding three-row window
// (top = r-1, middle = r, bottom = r+1). Rows outside the frame are either
// zero (WRAP=0) or taken toroidally (WRAP=1). Each accepted window triggers
// at most one row read, so the buffer holds exactly three row words.
module line_window_buffer #(
  parameter int WIDTH   = 1280,
  parameter int ROWS    = 720,
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 1,
  parameter int WRAP    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              fetch_en,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic [WIDTH-1:0]  fetch_data,
  output logic [WIDTH-1:0]  top,
  output logic [WIDTH-1:0]  middle,
  output logic [WIDTH-1:0]  bottom,
  output logic [ADDR_W-1:0] win_row,
  output logic              win_valid,
  input  logic              win_ready,
  output logic              frame_done
);

  typedef enum logic [1:0] {IDLE, PRIME, WAIT, EMIT} state_t;
  // Which window register a returning read word is written into.
  typedef enum logic [1:0] {DST_TOP, DST_MID, DST_BOT} dest_t;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] PEN_ROW  = ADDR_W'(ROWS - 2);

  // Row increment modulo ROWS; the compare comes first so the sum never
  // wraps through 2^ADDR_W even when ROWS == 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] row_inc(input logic [ADDR_W-1:0] r);
    return (r == LAST_ROW) ? '0 : r + ADDR_W'(1);
  endfunction

  state_t              state, state_nxt;
  dest_t               fetch_dest, fetch_dest_nxt;
  logic                busy_nxt, fetch_en_nxt, win_valid_nxt, frame_done_nxt;
  logic [ADDR_W-1:0]   fetch_addr_nxt, win_row_nxt;
  logic                shift_win, clear_top, clear_bot;

  // Read-return tracker: one slot per cycle of memory latency.
  logic [MEM_LAT-1:0]  pipe_v;
  dest_t               pipe_d [MEM_LAT];
  logic                cap_v;
  dest_t               cap_dest;

  assign cap_v    = pipe_v[MEM_LAT-1];
  assign cap_dest = pipe_d[MEM_LAT-1];

  // Next-state and next-output decode for the frame sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_nxt      = state;
    busy_nxt       = busy;
    fetch_en_nxt   = 1'b0;
    fetch_addr_nxt = fetch_addr;
    fetch_dest_nxt = fetch_dest;
    win_valid_nxt  = win_valid;
    win_row_nxt    = win_row;
    frame_done_nxt = 1'b0;
    shift_win      = 1'b0;
    clear_top      = 1'b0;
    clear_bot      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt      = PRIME;
          busy_nxt       = 1'b1;
          fetch_en_nxt   = 1'b1;
          win_row_nxt    = '0;
          clear_top      = (WRAP == 0);
          fetch_addr_nxt = (WRAP != 0) ? LAST_ROW : '0;
          fetch_dest_nxt = (WRAP != 0) ? DST_TOP : DST_MID;
        end
      end
      PRIME: begin
        // Back-to-back prime reads until the bottom row has been requested.
        if (fetch_dest != DST_BOT) begin
          fetch_en_nxt   = 1'b1;
          fetch_addr_nxt = row_inc(fetch_addr);
          fetch_dest_nxt = dest_t'(fetch_dest + 2'd1);
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cap_v && cap_dest == DST_BOT) begin
          state_nxt     = EMIT;
          win_valid_nxt = 1'b1;
        end
      end
      EMIT: begin
        if (win_ready) begin
          if (win_row == LAST_ROW) begin
            state_nxt      = IDLE;
            busy_nxt       = 1'b0;
            win_valid_nxt  = 1'b0;
            frame_done_nxt = 1'b1;
          end else begin
            shift_win   = 1'b1;
            win_row_nxt = row_inc(win_row);
            if (win_row == PEN_ROW && WRAP == 0) begin
              // Below the frame is a dead row: no read, window stays valid.
              clear_bot = 1'b1;
            end else begin
              win_valid_nxt  = 1'b0;
              fetch_en_nxt   = 1'b1;
              fetch_addr_nxt = row_inc(row_inc(win_row));
              fetch_dest_nxt = DST_BOT;
              state_nxt      = WAIT;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer state and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      fetch_en   <= 1'b0;
      fetch_addr <= '0;
      fetch_dest <= DST_TOP;
      win_valid  <= 1'b0;
      win_row    <= '0;
      frame_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed above, independent of statement order.
      state      <= state_nxt;
      busy       <= busy_nxt;
      fetch_en   <= fetch_en_nxt;
      fetch_addr <= fetch_addr_nxt;
      fetch_dest <= fetch_dest_nxt;
      win_valid  <= win_valid_nxt;
      win_row    <= win_row_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  // Delay each read strobe by the memory latency to mark its capture cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: clearing the tracker is what drops reads that were in flight
      // at reset; their data may still arrive but is never written.
      pipe_v <= '0;
      for (int i = 0; i < MEM_LAT; i++) pipe_d[i] <= DST_TOP;
    end else begin
      pipe_v[0] <= fetch_en;
      pipe_d[0] <= fetch_dest;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  // Window registers: clear, shift on accept, and capture returning rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top    <= '0;
      middle <= '0;
      bottom <= '0;
    end else begin
      if (clear_top) top <= '0;
      if (shift_win) begin
        top    <= middle;
        middle <= bottom;
      end
      if (clear_bot) bottom <= '0;
      if (cap_v) begin
        case (cap_dest)
          DST_TOP: top    <= fetch_data;
          DST_MID: middle <= fetch_data;
          DST_BOT: bottom <= fetch_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_line_window_buffer.sv
// Testbench for line_window_buffer. Three instances with ROWS=4, ADDR_W=2:
//   0: WRAP=0, MEM_LAT=1   1: WRAP=1, MEM_LAT=1   2: WRAP=0, MEM_LAT=3
// Memory row i holds i+1; a non-read cycle returns 8'hEE so a capture in the
// wrong cycle shows up as bad window data. Only one instance runs at a time.
module tb_line_window_buffer;
  localparam int W    = 8;
  localparam int ROWS = 4;
  localparam int AW   = 2;
  localparam int NI   = 3;

  typedef struct {
    int         inst;
    logic [W-1:0] t, m, b;
    int         row;
    int         cyc;
  } win_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  win_t exp_q[$];

  logic          rst_n;
  logic [NI-1:0] start, win_ready;
  wire  [NI-1:0] busy, fetch_en, win_valid, frame_done;
  wire  [AW-1:0] fetch_addr [NI];
  wire  [AW-1:0] win_row    [NI];
  wire  [W-1:0]  fetch_data [NI];
  wire  [W-1:0]  top        [NI];
  wire  [W-1:0]  middle     [NI];
  wire  [W-1:0]  bottom     [NI];

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    localparam int LAT = (g == 2) ? 3 : 1;

    line_window_buffer #(
      .WIDTH(W), .ROWS(ROWS), .ADDR_W(AW), .MEM_LAT(LAT), .WRAP((g == 1) ? 1 : 0)
    ) dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .busy(busy[g]),
      .fetch_en(fetch_en[g]), .fetch_addr(fetch_addr[g]), .fetch_data(fetch_data[g]),
      .top(top[g]), .middle(middle[g]), .bottom(bottom[g]), .win_row(win_row[g]),
      .win_valid(win_valid[g]), .win_ready(win_ready[g]), .frame_done(frame_done[g])
    );

    // Row memory model with LAT cycles of read latency.
    logic [W-1:0] mp [LAT];
    always @(posedge clk) begin
      mp[0] <= fetch_en[g] ? W'(fetch_addr[g]) + 8'd1 : 8'hEE;
      for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
    assign fetch_data[g] = mp[LAT-1];

    // Monitor: compare every valid cycle against the scoreboard head.
    bit   in_win = 1'b0;
    int   fd_due = -1;
    bit   ok_entry;
    win_t e;
    always @(negedge clk) begin
      if (!rst_n) begin
        in_win = 1'b0;
        fd_due = -1;
      end else begin
        check(frame_done[g] == (cyc == fd_due), $sformatf("frame_done[%0d]", g),
              frame_done[g], (cyc == fd_due));
        if (win_valid[g]) begin
          ok_entry = (exp_q.size() != 0) && (exp_q[0].inst == g);
          check(ok_entry, $sformatf("window_expected[%0d]", g), win_row[g], exp_q.size());
          if (ok_entry) begin
            e = exp_q[0];
            if (!in_win) begin
              in_win = 1'b1;
              check(cyc == e.cyc, $sformatf("valid_cycle[%0d] row%0d", g, e.row), cyc, e.cyc);
            end
            check(top[g]    == e.t, $sformatf("top[%0d] row%0d", g, e.row), top[g], e.t);
            check(middle[g] == e.m, $sformatf("middle[%0d] row%0d", g, e.row), middle[g], e.m);
            check(bottom[g] == e.b, $sformatf("bottom[%0d] row%0d", g, e.row), bottom[g], e.b);
            check(int'(win_row[g]) == e.row, $sformatf("win_row[%0d]", g), win_row[g], e.row);
            if (win_ready[g]) begin
              in_win = 1'b0;
              if (e.row == ROWS - 1) fd_due = cyc + 1;
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input int inst, input int t, input int m, input int b,
                      input int row, input int c);
    win_t w;
    w.inst = inst; w.t = W'(t); w.m = W'(m); w.b = W'(b); w.row = row; w.cyc = c;
    exp_q.push_back(w);
  endtask

  task automatic drain(input int limit);
    while (exp_q.size() != 0 && cyc < limit) tick();
    check(exp_q.size() == 0, "windows_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_zero(input string name);
    longint v;
    for (int i = 0; i < NI; i++) begin
      v = {busy[i], fetch_en[i], win_valid[i], frame_done[i], fetch_addr[i],
           win_row[i], top[i], middle[i], bottom[i]};
      check(v == 0, $sformatf("%s[%0d]", name, i), v, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n = 1'b0; start = '0; win_ready = '0;
    tick();
    check_zero("reset_state");
    rst_n = 1'b1;
    tick(); tick();

    // Instance 0: start held high for two frames, consumer always ready.
    t = cyc;
    push(0, 0, 1, 2, 0, t + 4);  push(0, 1, 2, 3, 1, t + 7);
    push(0, 2, 3, 4, 2, t + 10); push(0, 3, 4, 0, 3, t + 11);
    push(0, 0, 1, 2, 0, t + 16); push(0, 1, 2, 3, 1, t + 19);
    push(0, 2, 3, 4, 2, t + 22); push(0, 3, 4, 0, 3, t + 23);
    win_ready[0] = 1'b1; start[0] = 1'b1;
    tick();
    check(busy[0] == 1'b1, "busy_after_start", busy[0], 1);
    check(fetch_en[0] == 1'b1 && fetch_addr[0] == 2'd0, "prime_read0", {fetch_en[0], fetch_addr[0]}, 3'b100);
    tick();
    check(fetch_en[0] == 1'b1 && fetch_addr[0] == 2'd1, "prime_read1", {fetch_en[0], fetch_addr[0]}, 3'b101);
    tick();
    check(fetch_en[0] == 1'b0 && fetch_addr[0] == 2'd1, "fetch_idle_hold", {fetch_en[0], fetch_addr[0]}, 3'b001);
    go_to(t + 12);
    check(busy[0] == 1'b0 && fetch_en[0] == 1'b0, "idle_at_frame_done", {busy[0], fetch_en[0]}, 0);
    go_to(t + 13);
    check(busy[0] == 1'b1 && fetch_en[0] == 1'b1 && fetch_addr[0] == 2'd0,
          "restart_fetch", {busy[0], fetch_en[0], fetch_addr[0]}, 4'b1100);
    go_to(t + 24);
    start[0] = 1'b0;
    drain(t + 40);
    go_to(t + 27);
    check(busy[0] == 1'b0, "no_third_frame", busy[0], 0);

    // Instance 1: toroidal borders.
    t = cyc;
    push(1, 4, 1, 2, 0, t + 5);  push(1, 1, 2, 3, 1, t + 8);
    push(1, 2, 3, 4, 2, t + 11); push(1, 3, 4, 1, 3, t + 14);
    win_ready[1] = 1'b1; start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    check(fetch_en[1] == 1'b1 && fetch_addr[1] == 2'd3, "wrap_first_read", {fetch_en[1], fetch_addr[1]}, 3'b111);
    drain(t + 40);

    // Instance 2: MEM_LAT=3, consumer stalls 5 cycles on window row 1.
    t = cyc;
    push(2, 0, 1, 2, 0, t + 6);  push(2, 1, 2, 3, 1, t + 11);
    push(2, 2, 3, 4, 2, t + 21); push(2, 3, 4, 0, 3, t + 22);
    win_ready[2] = 1'b1; start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    go_to(t + 11);
    win_ready[2] = 1'b0;
    go_to(t + 16);
    win_ready[2] = 1'b1;
    drain(t + 50);

    // Instance 2: reset while the row-2 read is outstanding.
    t = cyc;
    push(2, 0, 1, 2, 0, t + 6);
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    go_to(t + 8);
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    tick();
    rst_n = 1'b1;
    go_to(t + 12);
    check_zero("no_capture_after_reset");
    check(exp_q.size() == 0, "reset_queue_empty", exp_q.size(), 0);
    exp_q.delete();

    // Instance 2: fresh frame after reset.
    t = cyc;
    push(2, 0, 1, 2, 0, t + 6);  push(2, 1, 2, 3, 1, t + 11);
    push(2, 2, 3, 4, 2, t + 16); push(2, 3, 4, 0, 3, t + 17);
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    drain(t + 40);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
